// File: rtl/pool_window_gen_if.sv
// Streaming pixel-in / neighbourhood-out bundle for the pooling window generator.
// The master side feeds pixels and consumes windows; the slave side is the generator.
interface pool_window_gen_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                      ena;
   logic                      in_valid;
   logic [DATA_WIDTH-1:0]     in_data;
   logic [9*DATA_WIDTH-1:0]   nh_vector;
   logic                      out_valid;
   logic                      frame_done;

   modport master (
      output ena,
      output in_valid,
      output in_data,
      input  nh_vector,
      input  out_valid,
      input  frame_done
   );

   modport slave (
      input  ena,
      input  in_valid,
      input  in_data,
      output nh_vector,
      output out_valid,
      output frame_done
   );
endinterface

// File: rtl/pool_window_gen.sv
// Streaming 3x3 neighbourhood generator for the max-pool stage: two row buffers plus a
// shifting 3x3 register window; stride-aligned windows are emitted one cycle after completion.
module pool_window_gen #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FM_WIDTH   = 8,
   parameter int unsigned FM_HEIGHT  = 8,
   parameter int unsigned STRIDE     = 2
) (
   input logic              clk,
   input logic              reset,
   pool_window_gen_if.slave bus
);
   localparam int unsigned NH_VECTOR_WIDTH = 9 * DATA_WIDTH;
   localparam int unsigned CW = $clog2(FM_WIDTH);
   localparam int unsigned RW = $clog2(FM_HEIGHT);
   localparam logic [1:0]  PhLast = 2'(STRIDE - 1);

   logic [CW-1:0]              r_col;
   logic [RW-1:0]              r_row;
   logic [1:0]                 r_col_ph;
   logic [1:0]                 r_row_ph;
   logic [DATA_WIDTH-1:0]      r_lb1 [FM_WIDTH];
   logic [DATA_WIDTH-1:0]      r_lb2 [FM_WIDTH];
   logic [DATA_WIDTH-1:0]      r_win [9];
   logic [NH_VECTOR_WIDTH-1:0] r_nh;
   logic                       r_out_valid;
   logic                       r_frame_done;

   logic                       w_acc;
   logic                       w_col_last;
   logic                       w_row_last;
   logic                       w_hit;
   logic [1:0]                 w_col_ph_next;
   logic [1:0]                 w_row_ph_next;
   logic [DATA_WIDTH-1:0]      w_win_next [9];
   logic [NH_VECTOR_WIDTH-1:0] w_nh_next;

   assign w_acc      = bus.ena & bus.in_valid;
   assign w_col_last = (r_col == CW'(FM_WIDTH - 1));
   assign w_row_last = (r_row == RW'(FM_HEIGHT - 1));

   // Phase counters track (col-2) mod STRIDE and (row-2) mod STRIDE without dividers.
   assign w_hit = (r_row >= RW'(2)) && (r_col >= CW'(2)) &&
                  (r_row_ph == 2'd0) && (r_col_ph == 2'd0);

   always_comb begin
      w_col_ph_next = (r_col < CW'(2) || r_col_ph == PhLast) ? 2'd0 : r_col_ph + 2'd1;
      w_row_ph_next = (r_row < RW'(2) || r_row_ph == PhLast) ? 2'd0 : r_row_ph + 2'd1;
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         w_win_next[3*i]   = r_win[3*i+1];
         w_win_next[3*i+1] = r_win[3*i+2];
         w_win_next[3*i+2] = '0;
      end
      w_win_next[2] = r_lb2[r_col];
      w_win_next[5] = r_lb1[r_col];
      w_win_next[8] = bus.in_data;
   end

   always_comb begin
      w_nh_next = '0;
      for (int k = 0; k < 9; k++) begin
         w_nh_next[k*DATA_WIDTH +: DATA_WIDTH] = w_win_next[k];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_col        <= '0;
         r_row        <= '0;
         r_col_ph     <= '0;
         r_row_ph     <= '0;
         r_nh         <= '0;
         r_out_valid  <= 1'b0;
         r_frame_done <= 1'b0;
         for (int k = 0; k < 9; k++) r_win[k] <= '0;
      end else if (bus.ena) begin
         // While ena is low the pulse registers hold, so a due pulse surfaces on release.
         r_out_valid  <= w_acc & w_hit;
         r_frame_done <= w_acc & w_col_last & w_row_last;
         if (w_acc) begin
            r_win    <= w_win_next;
            r_col_ph <= w_col_ph_next;
            if (w_hit) r_nh <= w_nh_next;
            if (w_col_last) begin
               r_col    <= '0;
               r_row_ph <= w_row_ph_next;
               r_row    <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
               r_col <= r_col + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset && w_acc) begin
         r_lb2[r_col] <= r_lb1[r_col];
         r_lb1[r_col] <= bus.in_data;
      end
   end

   assign bus.nh_vector  = r_nh;
   assign bus.out_valid  = r_out_valid & bus.ena;
   assign bus.frame_done = r_frame_done & bus.ena;
endmodule

// File: tb/tb_pool_window_gen.sv
// Bench for pool_window_gen: a 4x4/stride-1 and an 8x8/stride-2 instance, a per-cycle
// frame-array reference model, directed scenarios with a window table, and a random stream.
module tb_pool_window_gen;
   localparam int DW    = 16;
   localparam int NHW   = 9 * DW;
   localparam int NSCEN = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a;
   logic rst_b;
   pool_window_gen_if #(.DATA_WIDTH(DW)) if_a ();
   pool_window_gen_if #(.DATA_WIDTH(DW)) if_b ();

   pool_window_gen #(.DATA_WIDTH(DW), .FM_WIDTH(4), .FM_HEIGHT(4), .STRIDE(1)) u_dut_a (
      .clk   (clk),
      .reset (rst_a),
      .bus   (if_a)
   );
   pool_window_gen #(.DATA_WIDTH(DW), .FM_WIDTH(8), .FM_HEIGHT(8), .STRIDE(2)) u_dut_b (
      .clk   (clk),
      .reset (rst_b),
      .bus   (if_b)
   );

   typedef struct {
      int             scen;
      int             idx;
      logic [NHW-1:0] vec;
   } win_rec_t;

   typedef struct {
      int scen;
      int n_win;
      int n_done;
   } cnt_rec_t;

   int             n_checks = 0;
   int             n_errors = 0;
   int             cur_scen = 0;
   logic [NHW-1:0] cap [NSCEN][$];
   int             ov_cnt [NSCEN];
   int             fd_cnt [NSCEN];
   int             fd_alone [NSCEN];
   int             bub_ov [NSCEN];

   // Reference model state, per instance.
   int             m_cnt [2];
   bit             m_pv [2];
   bit             m_pd [2];
   logic [NHW-1:0] m_vec [2];
   logic [DW-1:0]  m_pix [2][8][8];
   bit             last_acc [2];

   function automatic int fw(input int s);
      return (s == 0) ? 4 : 8;
   endfunction
   function automatic int fh(input int s);
      return (s == 0) ? 4 : 8;
   endfunction
   function automatic int fs(input int s);
      return (s == 0) ? 1 : 2;
   endfunction

   function automatic logic [NHW-1:0] pk9(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5,
                                          input int a6, input int a7, input int a8);
      logic [NHW-1:0] v;
      v = '0;
      v[0*DW +: DW] = DW'(a0); v[1*DW +: DW] = DW'(a1); v[2*DW +: DW] = DW'(a2);
      v[3*DW +: DW] = DW'(a3); v[4*DW +: DW] = DW'(a4); v[5*DW +: DW] = DW'(a5);
      v[6*DW +: DW] = DW'(a6); v[7*DW +: DW] = DW'(a7); v[8*DW +: DW] = DW'(a8);
      return v;
   endfunction

   task automatic check(input string name, input logic [NHW-1:0] act,
                        input logic [NHW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock cycle on instance sel; the other instance is parked with ena low.
   task automatic step(input int sel, input bit rn, input bit en, input bit vld, input int d);
      logic           ov;
      logic           fd;
      logic [NHW-1:0] nh;
      int             r;
      int             c;
      if (sel == 0) begin
         rst_a = rn; if_a.ena = en; if_a.in_valid = vld; if_a.in_data = DW'(d);
         if_b.ena = 1'b0; if_b.in_valid = 1'b0;
      end else begin
         rst_b = rn; if_b.ena = en; if_b.in_valid = vld; if_b.in_data = DW'(d);
         if_a.ena = 1'b0; if_a.in_valid = 1'b0;
      end
      #1;
      if (sel == 0) begin
         ov = if_a.out_valid; fd = if_a.frame_done; nh = if_a.nh_vector;
      end else begin
         ov = if_b.out_valid; fd = if_b.frame_done; nh = if_b.nh_vector;
      end
      check($sformatf("s%0d dut%0d out_valid", cur_scen, sel), NHW'(ov),
            NHW'(m_pv[sel] && en));
      check($sformatf("s%0d dut%0d frame_done", cur_scen, sel), NHW'(fd),
            NHW'(m_pd[sel] && en));
      check($sformatf("s%0d dut%0d nh_vector", cur_scen, sel), nh, m_vec[sel]);
      if (ov === 1'b1) begin
         cap[cur_scen].push_back(nh);
         ov_cnt[cur_scen]++;
         if (!last_acc[sel]) bub_ov[cur_scen]++;
      end
      if (fd === 1'b1) begin
         fd_cnt[cur_scen]++;
         if (ov !== 1'b1) fd_alone[cur_scen]++;
      end
      @(posedge clk);
      if (!rn) begin
         m_cnt[sel] = 0; m_pv[sel] = 1'b0; m_pd[sel] = 1'b0; m_vec[sel] = '0;
      end else if (en) begin
         m_pv[sel] = 1'b0;
         m_pd[sel] = 1'b0;
         if (vld) begin
            r = m_cnt[sel] / fw(sel);
            c = m_cnt[sel] % fw(sel);
            m_pix[sel][r][c] = DW'(d);
            if (r >= 2 && c >= 2 && (r - 2) % fs(sel) == 0 && (c - 2) % fs(sel) == 0) begin
               m_pv[sel] = 1'b1;
               for (int i = 0; i < 3; i++)
                  for (int j = 0; j < 3; j++)
                     m_vec[sel][(3*i+j)*DW +: DW] = m_pix[sel][r-2+i][c-2+j];
            end
            if (r == fh(sel) - 1 && c == fw(sel) - 1) m_pd[sel] = 1'b1;
            m_cnt[sel] = (m_cnt[sel] + 1) % (fw(sel) * fh(sel));
         end
      end
      last_acc[sel] = rn && en && vld;
      @(negedge clk);
   endtask

   task automatic send_frame(input int sel, input int off, input bit bubbles);
      for (int n = 0; n < fw(sel) * fh(sel); n++) begin
         if (bubbles && $urandom_range(0, 1) == 1) step(sel, 1'b1, 1'b1, 1'b0, 0);
         step(sel, 1'b1, 1'b1, 1'b1, off + n);
      end
   endtask

   task automatic idle(input int sel, input int n);
      for (int k = 0; k < n; k++) step(sel, 1'b1, 1'b1, 1'b0, 0);
   endtask

   win_rec_t       wins [14];
   cnt_rec_t       cnts [6];
   logic [NHW-1:0] act;
   int             sel;

   initial begin
      // Expected windows, hand-derived from the pixel numbering of each scenario.
      wins[0]  = '{1, 0, pk9(0, 1, 2, 4, 5, 6, 8, 9, 10)};
      wins[1]  = '{1, 3, pk9(5, 6, 7, 9, 10, 11, 13, 14, 15)};
      wins[2]  = '{2, 0, pk9(0, 1, 2, 8, 9, 10, 16, 17, 18)};
      wins[3]  = '{2, 4, pk9(18, 19, 20, 26, 27, 28, 34, 35, 36)};
      wins[4]  = '{2, 8, pk9(36, 37, 38, 44, 45, 46, 52, 53, 54)};
      wins[5]  = '{3, 0, pk9(0, 1, 2, 4, 5, 6, 8, 9, 10)};
      wins[6]  = '{3, 3, pk9(5, 6, 7, 9, 10, 11, 13, 14, 15)};
      wins[7]  = '{4, 0, pk9(0, 1, 2, 4, 5, 6, 8, 9, 10)};
      wins[8]  = '{4, 3, pk9(5, 6, 7, 9, 10, 11, 13, 14, 15)};
      wins[9]  = '{5, 0, pk9(0, 1, 2, 4, 5, 6, 8, 9, 10)};
      wins[10] = '{5, 3, pk9(5, 6, 7, 9, 10, 11, 13, 14, 15)};
      wins[11] = '{6, 3, pk9(5, 6, 7, 9, 10, 11, 13, 14, 15)};
      wins[12] = '{6, 4, pk9(100, 101, 102, 104, 105, 106, 108, 109, 110)};
      wins[13] = '{6, 7, pk9(105, 106, 107, 109, 110, 111, 113, 114, 115)};
      cnts[0]  = '{1, 4, 1};
      cnts[1]  = '{2, 9, 1};
      cnts[2]  = '{3, 4, 1};
      cnts[3]  = '{4, 4, 1};
      cnts[4]  = '{5, 4, 1};
      cnts[5]  = '{6, 8, 2};

      for (int s = 0; s < 2; s++) begin
         m_cnt[s] = 0; m_pv[s] = 1'b0; m_pd[s] = 1'b0; m_vec[s] = '0; last_acc[s] = 1'b0;
      end
      rst_a = 1'b0; rst_b = 1'b0;
      if_a.ena = 1'b1; if_a.in_valid = 1'b0; if_a.in_data = '0;
      if_b.ena = 1'b1; if_b.in_valid = 1'b0; if_b.in_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_a = 1'b1; rst_b = 1'b1;
      #1;
      check("reset out_valid a", NHW'(if_a.out_valid), '0);
      check("reset frame_done a", NHW'(if_a.frame_done), '0);
      check("reset nh_vector a", if_a.nh_vector, '0);
      check("reset out_valid b", NHW'(if_b.out_valid), '0);
      check("reset frame_done b", NHW'(if_b.frame_done), '0);
      check("reset nh_vector b", if_b.nh_vector, '0);

      cur_scen = 1; send_frame(0, 0, 1'b0); idle(0, 3);
      cur_scen = 2; send_frame(1, 0, 1'b0); idle(1, 3);
      cur_scen = 3; send_frame(0, 0, 1'b1); idle(0, 3);

      // ena hold right after the completing pixel (2,2); pixels offered during hold are ignored.
      cur_scen = 4;
      for (int n = 0; n <= 10; n++) step(0, 1'b1, 1'b1, 1'b1, n);
      for (int k = 0; k < 5; k++) step(0, 1'b1, 1'b0, 1'b1, 999);
      for (int n = 11; n < 16; n++) step(0, 1'b1, 1'b1, 1'b1, n);
      idle(0, 3);

      cur_scen = 5;
      for (int n = 0; n < 7; n++) step(0, 1'b1, 1'b1, 1'b1, 50 + n);
      step(0, 1'b0, 1'b1, 1'b1, 77);
      step(0, 1'b0, 1'b1, 1'b1, 78);
      send_frame(0, 0, 1'b0); idle(0, 3);

      cur_scen = 6; send_frame(0, 0, 1'b0); send_frame(0, 100, 1'b0); idle(0, 3);

      cur_scen = 7;
      sel = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 300 == 0) sel = int'($urandom_range(0, 1));
         step(sel, $urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0,
              $urandom_range(0, 9) < 7, int'($urandom_range(0, 65535)));
      end

      foreach (wins[w]) begin
         act = (wins[w].idx < cap[wins[w].scen].size()) ? cap[wins[w].scen][wins[w].idx] : '1;
         check($sformatf("s%0d window %0d", wins[w].scen, wins[w].idx), act, wins[w].vec);
      end
      foreach (cnts[w]) begin
         check($sformatf("s%0d window count", cnts[w].scen), NHW'(ov_cnt[cnts[w].scen]),
               NHW'(cnts[w].n_win));
         check($sformatf("s%0d frame_done count", cnts[w].scen), NHW'(fd_cnt[cnts[w].scen]),
               NHW'(cnts[w].n_done));
      end
      check("s1 frame_done without out_valid", NHW'(fd_alone[1]), '0);
      check("s3 pulse after bubble", NHW'(bub_ov[3]), '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
